// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity subset enumerator.
package parity_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    function automatic int press_bits(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/mask_xor_reducer.sv
// XOR of the button masks selected by a subset; purely combinational.
module mask_xor_reducer #(
    parameter int MACHINE_COUNT = 10,
    parameter int BUTTON_COUNT  = 13
) (
    input  logic [BUTTON_COUNT*MACHINE_COUNT-1:0] masks,
    input  logic [BUTTON_COUNT-1:0]               subset,
    output logic [MACHINE_COUNT-1:0]              xor_vec
);

    logic [BUTTON_COUNT:0][MACHINE_COUNT-1:0] acc;

    assign acc[0] = '0;

    for (genvar b = 0; b < BUTTON_COUNT; b++) begin : g_btn
        assign acc[b+1] = acc[b] ^ (subset[b] ? masks[b*MACHINE_COUNT +: MACHINE_COUNT]
                                              : {MACHINE_COUNT{1'b0}});
    end

    assign xor_vec = acc[BUTTON_COUNT];

endmodule

// File: rtl/parity_subset_enumerator.sv
// Walks every button subset, streaming those whose mask XOR equals the target parity.
// Define PARITY_MIN_PRESS_EN to add min_found/min_presses tracking of accepted matches.
module parity_subset_enumerator
    import parity_pkg::*;
#(
    parameter int MACHINE_COUNT = 10,
    parameter int BUTTON_COUNT  = 13,
    parameter int PRESS_BITS    = press_bits(BUTTON_COUNT)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [MACHINE_COUNT-1:0]              parity,
    input  logic [BUTTON_COUNT*MACHINE_COUNT-1:0] button_masks,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  match_valid,
    input  logic                                  match_ready,
    output logic [BUTTON_COUNT-1:0]               match_subset,
    output logic [PRESS_BITS-1:0]                 match_presses
`ifdef PARITY_MIN_PRESS_EN
    ,
    output logic                                  min_found,
    output logic [PRESS_BITS-1:0]                 min_presses
`endif
);

    // One spare bit so the last-subset compare never sees a wrapped counter.
    localparam logic [BUTTON_COUNT:0] LAST = {1'b0, {BUTTON_COUNT{1'b1}}};

    state_t                                state_q, state_d;
    logic [BUTTON_COUNT:0]                 cnt_q, cnt_d;
    logic [MACHINE_COUNT-1:0]              par_q, par_d;
    logic [BUTTON_COUNT*MACHINE_COUNT-1:0] masks_q, masks_d;
    logic                                  busy_d, done_d, mv_d;
    logic [BUTTON_COUNT-1:0]               sub_d;
    logic [PRESS_BITS-1:0]                 prs_d;
    logic [MACHINE_COUNT-1:0]              xv;
    logic                                  eval;

    mask_xor_reducer #(
        .MACHINE_COUNT(MACHINE_COUNT),
        .BUTTON_COUNT (BUTTON_COUNT)
    ) u_xor (
        .masks  (masks_q),
        .subset (cnt_q[BUTTON_COUNT-1:0]),
        .xor_vec(xv)
    );

    assign eval = !match_valid || match_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        masks_d = masks_q;
        busy_d  = busy;
        done_d  = 1'b0;
        mv_d    = match_valid;
        sub_d   = match_subset;
        prs_d   = match_presses;
        case (state_q)
            IDLE: if (start) begin
                state_d = SCAN;
                par_d   = parity;
                masks_d = button_masks;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
            SCAN: if (eval) begin
                if (xv == par_q) begin
                    mv_d  = 1'b1;
                    sub_d = cnt_q[BUTTON_COUNT-1:0];
                    prs_d = PRESS_BITS'(popcount(32'(cnt_q[BUTTON_COUNT-1:0])));
                end else begin
                    mv_d = 1'b0;
                end
                if (cnt_q == LAST) state_d = DRAIN;
                else               cnt_d   = cnt_q + 1'b1;
            end
            DRAIN: if (eval) begin
                mv_d    = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            par_q         <= '0;
            masks_q       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            match_valid   <= 1'b0;
            match_subset  <= '0;
            match_presses <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            par_q         <= par_d;
            masks_q       <= masks_d;
            busy          <= busy_d;
            done          <= done_d;
            match_valid   <= mv_d;
            match_subset  <= sub_d;
            match_presses <= prs_d;
        end
    end

`ifdef PARITY_MIN_PRESS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_found   <= 1'b0;
            min_presses <= '0;
        end else if (state_q == IDLE && start) begin
            min_found   <= 1'b0;
            min_presses <= '0;
        end else if (match_valid && match_ready) begin
            min_found <= 1'b1;
            if (!min_found || match_presses < min_presses) min_presses <= match_presses;
        end
    end
`endif

endmodule

// File: tb/tb_parity_subset_enumerator.sv
// Bench for parity_subset_enumerator (4 counters, 3 buttons): vector table plus reset/backpressure sequences.
module tb_parity_subset_enumerator;

    localparam int MC = 4;
    localparam int BC = 3;
    localparam int PB = 2;

    logic             clk = 1'b0;
    logic             rst_n, start, match_ready;
    logic [MC-1:0]    parity;
    logic [BC*MC-1:0] button_masks;
    logic             busy, done, match_valid;
    logic [BC-1:0]    match_subset;
    logic [PB-1:0]    match_presses;
`ifdef PARITY_MIN_PRESS_EN
    logic             min_found;
    logic [PB-1:0]    min_presses;
`endif

    parity_subset_enumerator #(.MACHINE_COUNT(MC), .BUTTON_COUNT(BC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .parity(parity),
        .button_masks(button_masks), .busy(busy), .done(done),
        .match_valid(match_valid), .match_ready(match_ready),
        .match_subset(match_subset), .match_presses(match_presses)
`ifdef PARITY_MIN_PRESS_EN
        , .min_found(min_found), .min_presses(min_presses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  parity;
        logic [11:0] masks;
        int exp_n, exp_first, exp_first_p, exp_done;
        int stall_cyc, stall_len;
        bit busy_start, late_start;
        int exp_min_found, exp_min;
    } vec_t;

    typedef struct {
        logic [BC-1:0] sub;
        logic [PB-1:0] prs;
    } exp_t;

    vec_t tbl[8];
    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    bit   mon_en = 0;
    int   n_seen, first_sub, first_prs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Brute-force reference: every subset, in ascending order.
    task automatic push_expected(input logic [3:0] par, input logic [11:0] m);
        for (int s = 0; s < (1 << BC); s++) begin
            logic [MC-1:0] x;
            logic [BC-1:0] sv;
            exp_t e;
            sv = BC'(s);
            x  = '0;
            for (int b = 0; b < BC; b++) if (sv[b]) x ^= m[b*MC +: MC];
            if (x == par) begin
                e.sub = sv;
                e.prs = PB'($countones(sv));
                q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && match_valid && match_ready) begin
            if (n_seen == 0) begin
                first_sub = int'(match_subset);
                first_prs = int'(match_presses);
            end
            n_seen++;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_match: got subset %0d expected none", match_subset);
            end else begin
                e = q.pop_front();
                chk("match_subset", 32'(match_subset), 32'(e.sub));
                chk("match_presses", 32'(match_presses), 32'(e.prs));
            end
        end
    end

    task automatic run_scan(input vec_t t);
        bit found;
        q.delete();
        push_expected(t.parity, t.masks);
        n_seen = 0;
        first_sub = -1;
        first_prs = -1;
        found = 0;
        tick();
        start = 1; parity = t.parity; button_masks = t.masks; match_ready = 1;
        tick();
        start = 0; parity = MC'($urandom); button_masks = (BC*MC)'($urandom);
        mon_en = 1;
        for (int cyc = 1; cyc <= 100 && !found; cyc++) begin
            tick();
            if (cyc == 1) chk("busy_scan", 32'(busy), 1);
            if (t.stall_cyc != 0) begin
                if (cyc == t.stall_cyc) begin
                    chk("stall_valid", 32'(match_valid), 1);
                    match_ready = 0;
                end else if (cyc > t.stall_cyc && cyc <= t.stall_cyc + t.stall_len) begin
                    chk("stall_hold_valid", 32'(match_valid), 1);
                    chk("stall_hold_subset", 32'(match_subset), 32'(t.exp_first));
                    if (cyc == t.stall_cyc + t.stall_len) match_ready = 1;
                end
            end
            if (t.busy_start && cyc == 3) begin start = 1; parity = 4'b1000; end
            if (t.busy_start && cyc == 4) start = 0;
            if (t.late_start && cyc == t.exp_done - 1) start = 1;
            if (done) begin
                found = 1;
                start = 0;
                chk("done_latency", 32'(cyc), 32'(t.exp_done));
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        tick();
        chk("busy_after", 32'(busy), 0);
        chk("done_pulse_width", 32'(done), 0);
        chk("match_count", 32'(n_seen), 32'(t.exp_n));
        if (t.exp_n > 0) begin
            chk("first_subset", 32'(first_sub), 32'(t.exp_first));
            chk("first_presses", 32'(first_prs), 32'(t.exp_first_p));
        end
        chk("queue_drained", 32'(q.size()), 0);
`ifdef PARITY_MIN_PRESS_EN
        chk("min_found", 32'(min_found), 32'(t.exp_min_found));
        if (t.exp_min_found != 0) chk("min_presses", 32'(min_presses), 32'(t.exp_min));
`endif
        mon_en = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_valid"}, 32'(match_valid), 0);
        chk({tag, "_subset"}, 32'(match_subset), 0);
        chk({tag, "_presses"}, 32'(match_presses), 0);
`ifdef PARITY_MIN_PRESS_EN
        chk({tag, "_min_found"}, 32'(min_found), 0);
        chk({tag, "_min_presses"}, 32'(min_presses), 0);
`endif
    endtask

    initial begin
        // masks 12'h563: b0=0011, b1=0110, b2=0101
        tbl[0] = '{4'b0101, 12'h563, 2, 3, 2, 9, 0, 0, 0, 0, 1, 1};
        tbl[1] = '{4'b0000, 12'h563, 2, 0, 0, 9, 0, 0, 0, 0, 1, 0};
        tbl[2] = '{4'b1000, 12'h563, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{4'b0011, 12'h563, 2, 1, 1, 9, 0, 0, 0, 0, 1, 1};
        tbl[4] = '{4'b0110, 12'h563, 2, 2, 1, 9, 0, 0, 0, 0, 1, 1};
        tbl[5] = '{4'b1110, 12'h248, 1, 7, 3, 9, 0, 0, 0, 0, 1, 3};
        tbl[6] = '{4'b0101, 12'h563, 2, 3, 2, 14, 4, 5, 0, 0, 1, 1};
        tbl[7] = '{4'b0101, 12'h563, 2, 3, 2, 9, 0, 0, 1, 1, 1, 1};

        rst_n = 0; start = 0; match_ready = 1; parity = '0; button_masks = '0;
        #12;
        check_all_zero("reset");
        tick();
        rst_n = 1;

        for (int i = 0; i < 8; i++) run_scan(tbl[i]);

        // Reset in the middle of a scan: outputs clear at once, no done follows.
        q.delete();
        tick();
        start = 1; parity = 4'b0101; button_masks = 12'h563;
        tick();
        start = 0;
        repeat (4) tick();
        chk("pre_reset_valid", 32'(match_valid), 1);
        #2 rst_n = 0;
        #1 check_all_zero("midscan_reset");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_done_in_reset", 32'(done), 0);
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_done_after_reset", 32'(done), 0);
            chk("idle_after_reset", 32'(busy), 0);
        end

        run_scan(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
